// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART transmitter from a 1-byte requester (A)
// and a 2-byte requester (B, low byte first). Optional busy watchdog: UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int WIDTH       = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               A_REQ,
    input  logic [WIDTH-1:0]   A_DATA,
    output logic               A_ACK,
    input  logic               B_REQ,
    input  logic [2*WIDTH-1:0] B_DATA,
    output logic               B_ACK,
    input  logic               TX_BUSY,
    output logic [WIDTH-1:0]   TX_P_DATA,
    output logic               TX_D_VALID,
    output logic               ARB_BUSY,
    output logic               TIMEOUT_ERR
);

    if (WIDTH < 1 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("uart_tx_arbiter: WIDTH and TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t           state;
    state_t           state_nxt;

    // The low byte goes straight to TX_P_DATA at grant time; only the high byte is kept.
    logic [WIDTH-1:0] hi_byte;
    logic [WIDTH-1:0] hi_byte_nxt;
    logic             hi_pending;
    logic             hi_pending_nxt;
    logic             prefer_b;
    logic             prefer_b_nxt;

    logic             a_ack_nxt;
    logic             b_ack_nxt;
    logic             valid_nxt;
    logic [WIDTH-1:0] p_data_nxt;

    logic             grant_a;
    logic             grant_b;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_nxt;
    logic             retried;
    logic             retried_nxt;
    logic             err_nxt;
`endif

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == IDLE && !TX_BUSY) begin
            if (A_REQ && (!B_REQ || !prefer_b)) begin
                grant_a = 1'b1;
            end else if (B_REQ) begin
                grant_b = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        hi_byte_nxt    = hi_byte;
        hi_pending_nxt = hi_pending;
        prefer_b_nxt   = prefer_b;
        a_ack_nxt      = 1'b0;
        b_ack_nxt      = 1'b0;
        valid_nxt      = 1'b0;
        p_data_nxt     = TX_P_DATA;
`ifdef UART_TX_ARB_TIMEOUT_EN
        wd_cnt_nxt     = wd_cnt;
        retried_nxt    = retried;
        err_nxt        = TIMEOUT_ERR;
`endif

        case (state)
            IDLE: begin
                if (grant_a) begin
                    p_data_nxt     = A_DATA;
                    hi_byte_nxt    = '0;
                    hi_pending_nxt = 1'b0;
                    prefer_b_nxt   = 1'b1;
                    a_ack_nxt      = 1'b1;
                    valid_nxt      = 1'b1;
                    state_nxt      = SEND;
                end else if (grant_b) begin
                    p_data_nxt     = B_DATA[WIDTH-1:0];
                    hi_byte_nxt    = B_DATA[2*WIDTH-1:WIDTH];
                    hi_pending_nxt = 1'b1;
                    prefer_b_nxt   = 1'b0;
                    b_ack_nxt      = 1'b1;
                    valid_nxt      = 1'b1;
                    state_nxt      = SEND;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                retried_nxt = 1'b0;
`endif
            end

            SEND: begin
                state_nxt = WAIT_HI;
`ifdef UART_TX_ARB_TIMEOUT_EN
                wd_cnt_nxt = '0;
`endif
            end

            WAIT_HI: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_LO;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    retried_nxt = 1'b0;
`endif
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // First expiry retries the same byte (no ACK); a second one gives up.
                    if (retried) begin
                        err_nxt        = 1'b1;
                        hi_pending_nxt = 1'b0;
                        retried_nxt    = 1'b0;
                        state_nxt      = IDLE;
                    end else begin
                        retried_nxt = 1'b1;
                        valid_nxt   = 1'b1;
                        state_nxt   = SEND;
                    end
                end else begin
                    wd_cnt_nxt = wd_cnt + CNT_W'(1);
                end
`endif
            end

            WAIT_LO: begin
                if (!TX_BUSY) begin
                    if (hi_pending) begin
                        p_data_nxt     = hi_byte;
                        hi_pending_nxt = 1'b0;
                        valid_nxt      = 1'b1;
                        state_nxt      = SEND;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state      <= IDLE;
            hi_byte    <= '0;
            hi_pending <= 1'b0;
            prefer_b   <= 1'b0;
            A_ACK      <= 1'b0;
            B_ACK      <= 1'b0;
            TX_D_VALID <= 1'b0;
            TX_P_DATA  <= '0;
            ARB_BUSY   <= 1'b0;
        end else begin
            state      <= state_nxt;
            hi_byte    <= hi_byte_nxt;
            hi_pending <= hi_pending_nxt;
            prefer_b   <= prefer_b_nxt;
            A_ACK      <= a_ack_nxt;
            B_ACK      <= b_ack_nxt;
            TX_D_VALID <= valid_nxt;
            TX_P_DATA  <= p_data_nxt;
            ARB_BUSY   <= (state_nxt != IDLE);
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (!RST) begin
            wd_cnt      <= '0;
            retried     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            wd_cnt      <= wd_cnt_nxt;
            retried     <= retried_nxt;
            TIMEOUT_ERR <= err_nxt;
        end
    end
`else
    assign TIMEOUT_ERR = 1'b0;
`endif

endmodule
